// File: rtl/arb_pkg.sv
// Shared definitions for the round-robin grant arbiter.
//   arb_state_e : arbiter FSM state (IDLE / GRANT)
//   rr_pick     : behavioural round-robin pick, scanning ptr+1, ptr+2, ... (mod n)
//   onehot      : index to one-hot vector
// NMAX bounds the vector width the helper functions can handle.
package arb_pkg;

  typedef enum logic {
    IDLE  = 1'b0,
    GRANT = 1'b1
  } arb_state_e;

  localparam int unsigned NMAX = 32;

  // Returns the first set request after ptr (wrapping), or 0 when none is set.
  function automatic int rr_pick(input logic [NMAX-1:0] req, input int ptr, input int n);
    int  idx;
    bit  found;
    rr_pick = 0;
    found   = 1'b0;
    for (int k = 1; k <= n; k++) begin
      idx = (ptr + k) % n;
      if (!found && req[idx]) begin
        found   = 1'b1;
        rr_pick = idx;
      end
    end
  endfunction

  function automatic logic [NMAX-1:0] onehot(input int idx);
    onehot      = '0;
    onehot[idx] = 1'b1;
  endfunction

endpackage

// File: rtl/rr_pick_comb.sv
// Combinational round-robin selector.
//   req_i : request vector
//   ptr_i : index of the last holder; scanning starts at ptr_i+1
//   sel_o : index of the selected requester (0 when none)
//   vld_o : at least one request is set
// The request vector is rotated so that position 0 corresponds to ptr_i+1,
// priority-encoded, and the winning position mapped back to a real index.
module rr_pick_comb #(
  parameter  int N  = 4,
  localparam int IW = (N > 1) ? $clog2(N) : 1
) (
  input  logic [N-1:0]  req_i,
  input  logic [IW-1:0] ptr_i,
  output logic [IW-1:0] sel_o,
  output logic          vld_o
);

  logic [IW-1:0] rot_idx [N];
  logic [N-1:0]  rot;

  // rot[gi] is the request that sits gi+1 places after the pointer.
  for (genvar gi = 0; gi < N; gi++) begin : g_rot
    assign rot_idx[gi] = IW'((int'(ptr_i) + 1 + gi) % N);
    assign rot[gi]     = req_i[rot_idx[gi]];
  end

  always_comb begin
    logic found;
    found = 1'b0;
    sel_o = '0;
    for (int i = 0; i < N; i++) begin
      if (!found && rot[i]) begin
        found = 1'b1;
        sel_o = rot_idx[i];
      end
    end
  end

  assign vld_o = |req_i;

endmodule

// File: rtl/rr_grant_arbiter.sv
// Round-robin grant arbiter: resolves N level requests to a single one-hot
// holder, keeps the grant until DONE, request drop, or the hold limit.
//   clk_i       : rising-edge clock
//   rst_i       : synchronous active-high reset
//   req_i       : per-requester request, held until served
//   done_i      : holder releases the grant (1-cycle pulse)
//   any_o       : combinational OR of req_i
//   gnt_o       : registered one-hot grant, zero when idle
//   gnt_vld_o   : registered, high while a grant is held
//   gnt_id_o    : registered holder index, zero when idle
//   timeout_o   : registered 1-cycle pulse on a hold-limit release
// Every release passes through one IDLE cycle before re-arbitration, and the
// released holder becomes the pointer so it has lowest priority next time.
module rr_grant_arbiter
  import arb_pkg::*;
#(
  parameter  int N        = 4,
  parameter  int HOLD_MAX = 16,
  localparam int IW       = (N > 1) ? $clog2(N) : 1,
  localparam int CW       = $clog2(HOLD_MAX + 1)
) (
  input  logic          clk_i,
  input  logic          rst_i,
  input  logic [N-1:0]  req_i,
  input  logic          done_i,
  output logic          any_o,
  output logic [N-1:0]  gnt_o,
  output logic          gnt_vld_o,
  output logic [IW-1:0] gnt_id_o,
  output logic          timeout_o
);

  arb_state_e    state_q, state_d;
  logic [IW-1:0] ptr_q, ptr_d;
  logic [CW-1:0] hold_q, hold_d;
  logic [N-1:0]  gnt_q, gnt_d;
  logic [IW-1:0] id_q, id_d;
  logic          vld_q, vld_d;
  logic          to_q, to_d;

  logic [IW-1:0] pick_sel;
  logic          pick_vld;
  logic [N-1:0]  pick_oh;
  logic          holder_req;
  logic          hold_limit;

  rr_pick_comb #(.N(N)) u_pick (
    .req_i (req_i),
    .ptr_i (ptr_q),
    .sel_o (pick_sel),
    .vld_o (pick_vld)
  );

  for (genvar gi = 0; gi < N; gi++) begin : g_oh
    assign pick_oh[gi] = (pick_sel == IW'(gi));
  end

  assign any_o      = pick_vld;
  assign holder_req = req_i[id_q];
  assign hold_limit = (hold_q == CW'(HOLD_MAX - 1));

  always_comb begin
    state_d = state_q;
    ptr_d   = ptr_q;
    hold_d  = hold_q;
    gnt_d   = gnt_q;
    id_d    = id_q;
    vld_d   = vld_q;
    to_d    = 1'b0;
    case (state_q)
      IDLE: begin
        if (pick_vld) begin
          gnt_d   = pick_oh;
          id_d    = pick_sel;
          vld_d   = 1'b1;
          hold_d  = '0;
          state_d = GRANT;
        end
      end
      GRANT: begin
        if (done_i || !holder_req || hold_limit) begin
          gnt_d   = '0;
          vld_d   = 1'b0;
          id_d    = '0;
          ptr_d   = id_q;
          state_d = IDLE;
          // Only the hold limit alone counts as a forced release.
          to_d    = !done_i && holder_req;
        end else if (hold_q != CW'(HOLD_MAX)) begin
          hold_d = hold_q + CW'(1);
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      state_q <= IDLE;
      ptr_q   <= IW'(N - 1);
      hold_q  <= '0;
      gnt_q   <= '0;
      id_q    <= '0;
      vld_q   <= 1'b0;
      to_q    <= 1'b0;
    end else begin
      state_q <= state_d;
      ptr_q   <= ptr_d;
      hold_q  <= hold_d;
      gnt_q   <= gnt_d;
      id_q    <= id_d;
      vld_q   <= vld_d;
      to_q    <= to_d;
    end
  end

  assign gnt_o     = gnt_q;
  assign gnt_vld_o = vld_q;
  assign gnt_id_o  = id_q;
  assign timeout_o = to_q;

endmodule

// File: tb/tb_rr_grant_arbiter.sv
module tb_rr_grant_arbiter;

  logic       clk;
  logic       rst;
  logic [3:0] req;
  logic       done;
  logic       any;
  logic [3:0] gnt;
  logic       gnt_vld;
  logic [1:0] gnt_id;
  logic       timeout;

  int n_checks = 0;
  int n_fail   = 0;

  rr_grant_arbiter #(.N(4), .HOLD_MAX(16)) dut (
    .clk_i     (clk),
    .rst_i     (rst),
    .req_i     (req),
    .done_i    (done),
    .any_o     (any),
    .gnt_o     (gnt),
    .gnt_vld_o (gnt_vld),
    .gnt_id_o  (gnt_id),
    .timeout_o (timeout)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    if (obs !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic chk_out(input string tag, input logic [3:0] g, input logic [1:0] id,
                         input logic to);
    check({tag, ".gnt"}, 32'(gnt), 32'(g));
    check({tag, ".vld"}, 32'(gnt_vld), 32'(g != 4'b0));
    check({tag, ".id"},  32'(gnt_id), 32'(id));
    check({tag, ".to"},  32'(timeout), 32'(to));
    $display("%s: req=%b gnt=%b id=%0d vld=%b to=%b", tag, req, gnt, gnt_id, gnt_vld, timeout);
  endtask

  task automatic do_reset();
    rst = 1'b1;
    tick();
    rst = 1'b0;
  endtask

  // Structural invariants, checked every cycle away from the edge.
  always @(negedge clk) begin
    if (!rst) begin
      check("inv.onehot0", 32'($onehot0(gnt)), 32'd1);
      check("inv.vld_or",  32'(gnt_vld), 32'(|gnt));
    end
  end

  logic [3:0] rr_exp [5];

  initial begin
    rst  = 1'b1;
    req  = 4'b1111;
    done = 1'b0;

    // 1: reset held with all requests asserted
    for (int i = 0; i < 3; i++) begin
      tick();
      chk_out("rst_hold", 4'b0000, 2'd0, 1'b0);
      check("rst_hold.any", 32'(any), 32'd1);
    end
    rst = 1'b0;
    req = 4'b0100;

    // 2: single request, one cycle latency, DONE release
    tick();
    chk_out("single.grant", 4'b0100, 2'd2, 1'b0);
    done = 1'b1;
    tick();
    done = 1'b0;
    chk_out("single.release", 4'b0000, 2'd0, 1'b0);
    req = 4'b0000;
    #1;
    check("single.any0", 32'(any), 32'd0);

    // 3: all requesting, DONE each grant -> 0,1,2,3,0 with idle gaps
    do_reset();
    req = 4'b1111;
    rr_exp[0] = 4'b0001; rr_exp[1] = 4'b0010; rr_exp[2] = 4'b0100;
    rr_exp[3] = 4'b1000; rr_exp[4] = 4'b0001;
    for (int i = 0; i < 5; i++) begin
      tick();
      chk_out($sformatf("rr.grant%0d", i), rr_exp[i], 2'(i % 4), 1'b0);
      done = 1'b1;
      tick();
      done = 1'b0;
      chk_out($sformatf("rr.idle%0d", i), 4'b0000, 2'd0, 1'b0);
    end
    req = 4'b0000;
    tick();
    chk_out("rr.quiet", 4'b0000, 2'd0, 1'b0);

    // 4: hold limit -> 16 cycles held, TIMEOUT pulse, regrant after idle
    do_reset();
    req = 4'b0001;
    tick();
    for (int i = 0; i < 16; i++) begin
      check($sformatf("hold.gnt%0d", i), 32'(gnt), 32'h1);
      check($sformatf("hold.to%0d", i), 32'(timeout), 32'h0);
      tick();
    end
    chk_out("hold.timeout", 4'b0000, 2'd0, 1'b1);
    tick();
    chk_out("hold.regrant", 4'b0001, 2'd0, 1'b0);
    req = 4'b0000;
    tick();
    chk_out("hold.drop", 4'b0000, 2'd0, 1'b0);

    // 5: holder drops REQ mid-grant; next scan starts after the holder
    req = 4'b0010;
    tick();
    chk_out("drop.grant1", 4'b0010, 2'd1, 1'b0);
    tick();
    chk_out("drop.held", 4'b0010, 2'd1, 1'b0);
    req = 4'b1001;
    tick();
    chk_out("drop.release", 4'b0000, 2'd0, 1'b0);
    tick();
    chk_out("drop.next3", 4'b1000, 2'd3, 1'b0);
    done = 1'b1;
    tick();
    done = 1'b0;
    req  = 4'b0000;
    chk_out("drop.done", 4'b0000, 2'd0, 1'b0);

    // 6: reset during GRANT together with DONE
    req = 4'b0110;
    tick();
    chk_out("rstg.grant1", 4'b0010, 2'd1, 1'b0);
    done = 1'b1;
    tick();
    done = 1'b0;
    tick();
    chk_out("rstg.grant2", 4'b0100, 2'd2, 1'b0);
    tick();
    rst  = 1'b1;
    done = 1'b1;
    tick();
    rst  = 1'b0;
    done = 1'b0;
    chk_out("rstg.cleared", 4'b0000, 2'd0, 1'b0);
    tick();
    chk_out("rstg.lowest", 4'b0010, 2'd1, 1'b0);
    tick();
    chk_out("rstg.no_to", 4'b0010, 2'd1, 1'b0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
